vend_transaction_ctrl: RTL and testbench

//  Customer-side transaction controller: initiator for the store handler's mode/productCode/itemCount command port.

---
 rtl/vend_transaction_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_vend_transaction_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_transaction_ctrl.sv
// vend_transaction_ctrl
// Customer-side transaction controller. It takes a product selection and coin pulses from the
// coin/keypad front-end and looks up price and stock through the store handler's lookup port.
// It issues exactly one buy command when stock and credit both suffice, and then returns change.
//
// Parameters
//   MaxCredit       credit ceiling. A coin that would push credit past it is rejected (<= 255).
//   TimeoutCycles   idle cycles in the collect phase before an automatic cancel and refund.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous, active-high reset
//   select_valid_i   one-cycle product request strobe
//   select_code_i    requested product code
//   select_count_i   requested item count (0 = ignored)
//   coin_valid_i     one-cycle coin strobe
//   coin_value_i     coin value, in units
//   cancel_i         customer abort
//   price_i          store price of product_code_o, sampled during the lookup cycle
//   stock_i          store stock of product_code_o, same timing as price_i
//   cmd_valid_o      buy command strobe to the store handler
//   mode_o           2'b01 while cmd_valid_o is high, otherwise 2'b11 (no-op)
//   product_code_o   latched select code; also addresses the price/stock lookup
//   item_count_o     latched select count
//   dispense_o       one-cycle pulse, same cycle as cmd_valid_o
//   change_valid_o   one-cycle pulse, change_amount_o valid
//   change_amount_o  refund or change value; holds until the next change_valid_o
//   coin_reject_o    one-cycle pulse: coin not accepted (returned to the customer)
//   err_stock_o      one-cycle pulse: stock is below the requested count
module vend_transaction_ctrl #(
  parameter int unsigned MaxCredit     = 255,
  parameter int unsigned TimeoutCycles = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       select_valid_i,
  input  logic [2:0] select_code_i,
  input  logic [3:0] select_count_i,
  input  logic       coin_valid_i,
  input  logic [3:0] coin_value_i,
  input  logic       cancel_i,
  input  logic [3:0] price_i,
  input  logic [3:0] stock_i,
  output logic       cmd_valid_o,
  output logic [1:0] mode_o,
  output logic [2:0] product_code_o,
  output logic [3:0] item_count_o,
  output logic       dispense_o,
  output logic       change_valid_o,
  output logic [7:0] change_amount_o,
  output logic       coin_reject_o,
  output logic       err_stock_o
);

  localparam int unsigned     IdleW      = $clog2(TimeoutCycles + 1);
  localparam logic [8:0]      MaxCreditW = 9'(MaxCredit);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(TimeoutCycles);

  localparam logic [1:0] ModeBuy  = 2'b01;
  localparam logic [1:0] ModeNoop = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCollect,
    StCommit,
    StRefund
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       credit_q, credit_d;
  logic [7:0]       cost_q, cost_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [2:0]       code_q, code_d;
  logic [3:0]       count_q, count_d;

  // Registered outputs and their next-state values.
  logic       cmd_valid_q, cmd_valid_d;
  logic [1:0] mode_q, mode_d;
  logic       dispense_q, dispense_d;
  logic       change_valid_q, change_valid_d;
  logic [7:0] change_amount_q, change_amount_d;
  logic       coin_reject_q, coin_reject_d;
  logic       err_stock_q, err_stock_d;

  // Change owed on entry to the refund state; only meaningful when state_d is StRefund.
  logic [7:0] change_d;

  logic [8:0] coin_sum;
  logic       coin_fits;
  logic       timeout;
  logic       stock_short;
  logic       coin_accept;

  assign coin_sum    = {1'b0, credit_q} + {5'b0, coin_value_i};
  assign coin_fits   = (coin_sum <= MaxCreditW);
  assign timeout     = (idle_q == IdleMax);
  assign stock_short = (stock_i < count_q);

  // Coins are only taken while collecting; a simultaneous cancel or timeout wins over the coin.
  assign coin_accept = (state_q == StCollect) && coin_valid_i && !cancel_i && !timeout &&
                       coin_fits;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      credit_q <= '0;
      cost_q   <= '0;
      idle_q   <= '0;
      code_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cost_q   <= cost_d;
      idle_q   <= idle_d;
      code_q   <= code_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cost_d   = cost_q;
    idle_d   = idle_q;
    code_d   = code_q;
    count_d  = count_q;
    change_d = '0;

    unique case (state_q)
      StIdle: begin
        if (select_valid_i && (select_count_i != 4'd0)) begin
          code_d  = select_code_i;
          count_d = select_count_i;
          state_d = StLookup;
        end
      end

      StLookup: begin
        // 4x4 product never exceeds 225, so 8 bits hold it exactly.
        cost_d = {4'b0, price_i} * {4'b0, count_q};
        if (stock_short) begin
          state_d = StIdle;
        end else begin
          idle_d  = '0;
          state_d = StCollect;
        end
      end

      StCollect: begin
        if (cancel_i || timeout) begin
          change_d = credit_q;
          state_d  = StRefund;
        end else begin
          if (coin_accept) begin
            credit_d = coin_sum[7:0];
            idle_d   = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
          // Compare against registered credit, so a coin takes effect one cycle later.
          if (credit_q >= cost_q) begin
            state_d = StCommit;
          end
        end
      end

      StCommit: begin
        change_d = credit_q - cost_q;
        state_d  = StRefund;
      end

      StRefund: begin
        credit_d = '0;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic: next values for the output registers, decoded from the next state
  // so that pulses line up with the state they belong to.
  always_comb begin
    cmd_valid_d     = (state_d == StCommit);
    dispense_d      = (state_d == StCommit);
    mode_d          = (state_d == StCommit) ? ModeBuy : ModeNoop;
    change_valid_d  = (state_d == StRefund) && (change_d != 8'd0);
    change_amount_d = change_valid_d ? change_d : change_amount_q;
    coin_reject_d   = coin_valid_i && !coin_accept;
    err_stock_d     = (state_q == StLookup) && stock_short;
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q     <= 1'b0;
      mode_q          <= ModeNoop;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      coin_reject_q   <= 1'b0;
      err_stock_q     <= 1'b0;
    end else begin
      cmd_valid_q     <= cmd_valid_d;
      mode_q          <= mode_d;
      dispense_q      <= dispense_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      coin_reject_q   <= coin_reject_d;
      err_stock_q     <= err_stock_d;
    end
  end

  assign cmd_valid_o     = cmd_valid_q;
  assign mode_o          = mode_q;
  assign product_code_o  = code_q;
  assign item_count_o    = count_q;
  assign dispense_o      = dispense_q;
  assign change_valid_o  = change_valid_q;
  assign change_amount_o = change_amount_q;
  assign coin_reject_o   = coin_reject_q;
  assign err_stock_o     = err_stock_q;

endmodule

// File: tb/tb_vend_transaction_ctrl.sv
// tb_vend_transaction_ctrl
// Self-checking bench for vend_transaction_ctrl. Expected output events are queued as stimulus
// is driven; a negedge monitor pops and compares them as the DUT pulses its outputs.
module tb_vend_transaction_ctrl;

  localparam int EvErr    = 0;
  localparam int EvReject = 1;
  localparam int EvCmd    = 2;
  localparam int EvChange = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       select_valid;
  logic [2:0] select_code;
  logic [3:0] select_count;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       cancel;
  logic [3:0] price;
  logic [3:0] stock;
  logic       cmd_valid;
  logic [1:0] mode;
  logic [2:0] product_code;
  logic [3:0] item_count;
  logic       dispense;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic       err_stock;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  vend_transaction_ctrl #(
    .MaxCredit    (20),
    .TimeoutCycles(8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .select_valid_i (select_valid),
    .select_code_i  (select_code),
    .select_count_i (select_count),
    .coin_valid_i   (coin_valid),
    .coin_value_i   (coin_value),
    .cancel_i       (cancel),
    .price_i        (price),
    .stock_i        (stock),
    .cmd_valid_o    (cmd_valid),
    .mode_o         (mode),
    .product_code_o (product_code),
    .item_count_o   (item_count),
    .dispense_o     (dispense),
    .change_valid_o (change_valid),
    .change_amount_o(change_amount),
    .coin_reject_o  (coin_reject),
    .err_stock_o    (err_stock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input int kind, input logic [31:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_unexpected_event", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_val("sb_kind", kind, e.kind);
      check_val("sb_data", data, e.data);
    end
  endtask

  // Pulses from one cycle are handled in a fixed order: err, reject, cmd, change.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_stock)    sb_compare(EvErr, 32'd0);
      if (coin_reject)  sb_compare(EvReject, 32'd0);
      if (cmd_valid)    sb_compare(EvCmd, {21'd0, dispense, mode, product_code, item_count});
      if (change_valid) sb_compare(EvChange, {24'd0, change_amount});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe a selection, then step past the lookup cycle.
  task automatic do_select(input logic [2:0] code, input logic [3:0] cnt);
    select_valid = 1'b1;
    select_code  = code;
    select_count = cnt;
    tick();
    select_valid = 1'b0;
    tick();
  endtask

  task automatic do_coin(input logic [3:0] value);
    coin_valid = 1'b1;
    coin_value = value;
    tick();
    coin_valid = 1'b0;
    tick();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_val("sb_drain", sb_q.size(), 0);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] cmd_word(input logic [2:0] code, input logic [3:0] cnt);
    return {21'd0, 1'b1, 2'b01, code, cnt};
  endfunction

  initial begin
    rst          = 1'b1;
    select_valid = 1'b0;
    select_code  = '0;
    select_count = '0;
    coin_valid   = 1'b0;
    coin_value   = '0;
    cancel       = 1'b0;
    price        = '0;
    stock        = '0;
    tick();
    tick();

    // Reset state
    check_val("rst_cmd_valid", cmd_valid, 0);
    check_val("rst_mode", mode, 3);
    check_val("rst_dispense", dispense, 0);
    check_val("rst_change_valid", change_valid, 0);
    check_val("rst_change_amount", change_amount, 0);
    check_val("rst_coin_reject", coin_reject, 0);
    check_val("rst_err_stock", err_stock, 0);
    rst = 1'b0;
    tick();

    // 1. Buy: cost 12, credit 15 -> command then change 3
    price = 4'd4;
    stock = 4'd10;
    push_exp(EvCmd, cmd_word(3'd2, 4'd3));
    push_exp(EvChange, 32'd3);
    do_select(3'd2, 4'd3);
    do_coin(4'd5);
    do_coin(4'd5);
    do_coin(4'd5);
    wait_drain(20);
    check_val("idle_mode", mode, 3);

    // Exact stock and exact credit: command, zero change gives no change pulse
    price = 4'd2;
    stock = 4'd3;
    push_exp(EvCmd, cmd_word(3'd6, 4'd3));
    do_select(3'd6, 4'd3);
    do_coin(4'd5);
    do_coin(4'd1);
    wait_drain(20);
    check_val("change_amount_hold", change_amount, 3);

    // 2. Out of stock, then a coin in idle is rejected
    price = 4'd1;
    stock = 4'd2;
    push_exp(EvErr, 32'd0);
    do_select(3'd5, 4'd3);
    wait_drain(10);
    push_exp(EvReject, 32'd0);
    do_coin(4'd1);
    wait_drain(10);

    // Zero count selection is ignored, so the next coin still meets an idle controller
    stock = 4'd9;
    do_select(3'd4, 4'd0);
    push_exp(EvReject, 32'd0);
    do_coin(4'd2);
    wait_drain(10);

    // 3. Cancel refunds collected credit
    price = 4'd9;
    stock = 4'd5;
    do_select(3'd1, 4'd1);
    do_coin(4'd4);
    do_coin(4'd3);
    push_exp(EvChange, 32'd7);
    do_cancel();
    wait_drain(10);

    // 4. Cancel and coin together: the coin is rejected and only credit 2 comes back
    do_select(3'd1, 4'd1);
    do_coin(4'd2);
    push_exp(EvReject, 32'd0);
    push_exp(EvChange, 32'd2);
    coin_valid = 1'b1;
    coin_value = 4'd5;
    do_cancel();
    coin_valid = 1'b0;
    wait_drain(10);

    // 5. Timeout after 8 idle cycles refunds credit 3
    do_select(3'd1, 4'd1);
    do_coin(4'd3);
    push_exp(EvChange, 32'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("timeout_early", change_valid, 0);
    end
    wait_drain(20);

    // 6. Credit ceiling: 15 accepted, 15 rejected, 5 accepted (exactly 20), cancel -> 20
    price = 4'd15;
    stock = 4'd5;
    do_select(3'd3, 4'd2);
    do_coin(4'd15);
    push_exp(EvReject, 32'd0);
    do_coin(4'd15);
    do_coin(4'd5);
    push_exp(EvChange, 32'd20);
    do_cancel();
    wait_drain(10);

    // Reset mid-collect discards credit without a change pulse
    do_select(3'd3, 4'd2);
    do_coin(4'd15);
    push_exp(EvReject, 32'd0);
    do_coin(4'd15);
    check_val("sb_before_reset", sb_q.size(), 0);
    rst = 1'b1;
    tick();
    tick();
    check_val("mid_rst_cmd_valid", cmd_valid, 0);
    check_val("mid_rst_mode", mode, 3);
    check_val("mid_rst_change_valid", change_valid, 0);
    check_val("mid_rst_change_amount", change_amount, 0);
    check_val("mid_rst_item_count", item_count, 0);
    check_val("mid_rst_product_code", product_code, 0);
    rst = 1'b0;
    repeat (12) tick();
    push_exp(EvReject, 32'd0);
    do_coin(4'd1);
    wait_drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
